// File: rtl/turbo_pkg.sv
// Shared types and constants for the turbo encoder readout path.
package turbo_pkg;

  localparam int unsigned SymWDefault = 6;
  localparam int unsigned WordW       = 32;
  localparam int unsigned CountW      = 3;

  // Frame FSM encoding
  typedef logic [0:0] frame_state_t;
  localparam frame_state_t StIdle    = 1'b0;
  localparam frame_state_t StInFrame = 1'b1;

  typedef struct packed {
    logic [WordW-1:0]  data;
    logic [CountW-1:0] count;
    logic              bof;
    logic              eof;
  } fifo_entry_t;

endpackage

// File: rtl/turbo_word_fifo.sv
// Synchronous FIFO of packed word entries; head is read combinationally from storage.
module turbo_word_fifo
  import turbo_pkg::*;
#(
  parameter int unsigned Depth = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        wr_i,
  input  fifo_entry_t wr_entry_i,
  input  logic        rd_i,
  output fifo_entry_t rd_entry_o,
  output logic        full_o,
  output logic        empty_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  logic [PtrW:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW:0] rd_ptr_q, rd_ptr_d;
  fifo_entry_t   mem_q [Depth];
  logic          wr_fire, rd_fire;

  // Extra wrap bit distinguishes full from empty when the indices match.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                   (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);

  assign wr_fire    = wr_i & ~full_o;
  assign rd_fire    = rd_i & ~empty_o;
  assign rd_entry_o = mem_q[rd_ptr_q[PtrW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_fire) wr_ptr_d = wr_ptr_q + {{PtrW{1'b0}}, 1'b1};
    if (rd_fire) rd_ptr_d = rd_ptr_q + {{PtrW{1'b0}}, 1'b1};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_fire) mem_q[wr_ptr_q[PtrW-1:0]] <= wr_entry_i;
  end

endmodule

// File: rtl/turbo_symbol_packer.sv
// Packs coded symbols into 32-bit words with frame markers and flags framing errors.
module turbo_symbol_packer
  import turbo_pkg::*;
#(
  parameter int unsigned SYM_W         = SymWDefault,
  parameter int unsigned SYMS_PER_WORD = 5,
  parameter int unsigned FIFO_DEPTH    = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  input  logic [SYM_W-1:0]  i_data,
  input  logic              i_bof,
  input  logic              i_eof,
  output logic              o_ready,
  output logic              o_valid,
  output logic [WordW-1:0]  o_data,
  output logic [CountW-1:0] o_count,
  output logic              o_bof,
  output logic              o_eof,
  input  logic              i_ready,
  output logic              o_err
);

  localparam logic [CountW-1:0] FullCount = CountW'(SYMS_PER_WORD);

  typedef logic [SYMS_PER_WORD-1:0][SYM_W-1:0] slots_t;

  frame_state_t      state_q, state_d;
  slots_t            slots_q, slots_d;
  logic [CountW-1:0] count_q, count_d;
  logic              word_bof_q, word_bof_d;
  logic              err_q, err_d;

  logic              accept;
  logic              do_insert;
  logic              partial_flush;
  logic [CountW-1:0] ins_idx;
  logic [CountW-1:0] new_count;
  logic              ins_bof;
  logic              wr_en;
  fifo_entry_t       wr_entry;
  fifo_entry_t       head;
  logic              fifo_full, fifo_empty;

  // Slots at or beyond n are forced to zero so stale symbols never leak out.
  function automatic logic [WordW-1:0] pack_word(input slots_t s, input logic [CountW-1:0] n);
    logic [WordW-1:0] w;
    w = '0;
    for (int k = 0; k < int'(SYMS_PER_WORD); k++) begin
      if (k < int'(n)) w[SYM_W*k +: SYM_W] = s[k];
    end
    return w;
  endfunction

  assign accept = i_valid & o_ready;

  always_comb begin
    state_d       = state_q;
    slots_d       = slots_q;
    count_d       = count_q;
    word_bof_d    = word_bof_q;
    err_d         = err_q;
    do_insert     = 1'b0;
    partial_flush = 1'b0;
    ins_idx       = count_q;
    ins_bof       = word_bof_q;
    new_count     = '0;
    wr_en         = 1'b0;
    wr_entry      = '0;

    if (accept) begin
      if (state_q == StIdle) begin
        if (i_bof) begin
          do_insert = 1'b1;
          ins_idx   = '0;
          ins_bof   = 1'b1;
          state_d   = StInFrame;
        end else begin
          err_d = 1'b1;
        end
      end else if (i_bof) begin
        // Missing eof: close the open word, then restart at slot 0.
        err_d     = 1'b1;
        do_insert = 1'b1;
        ins_idx   = '0;
        ins_bof   = 1'b1;
        if (count_q != '0) begin
          partial_flush  = 1'b1;
          wr_en          = 1'b1;
          wr_entry.data  = pack_word(slots_q, count_q);
          wr_entry.count = count_q;
          wr_entry.bof   = word_bof_q;
          wr_entry.eof   = 1'b1;
        end
      end else begin
        do_insert = 1'b1;
      end

      if (do_insert) begin
        slots_d[ins_idx] = i_data;
        new_count        = ins_idx + CountW'(1);
        // Only one FIFO write per cycle: a partial flush defers this word.
        if (!partial_flush && (i_eof || new_count == FullCount)) begin
          wr_en          = 1'b1;
          wr_entry.data  = pack_word(slots_d, new_count);
          wr_entry.count = new_count;
          wr_entry.bof   = ins_bof;
          wr_entry.eof   = i_eof;
          count_d        = '0;
          word_bof_d     = 1'b0;
          if (i_eof) state_d = StIdle;
        end else begin
          count_d    = new_count;
          word_bof_d = ins_bof;
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= StIdle;
      slots_q    <= '0;
      count_q    <= '0;
      word_bof_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      slots_q    <= slots_d;
      count_q    <= count_d;
      word_bof_q <= word_bof_d;
      err_q      <= err_d;
    end
  end

  turbo_word_fifo #(
    .Depth(FIFO_DEPTH)
  ) u_fifo (
    .clk_i     (i_clk),
    .rst_i     (i_rst),
    .wr_i      (wr_en),
    .wr_entry_i(wr_entry),
    .rd_i      (i_ready),
    .rd_entry_o(head),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  assign o_ready = ~fifo_full;
  assign o_valid = ~fifo_empty;
  assign o_data  = o_valid ? head.data  : '0;
  assign o_count = o_valid ? head.count : '0;
  assign o_bof   = o_valid & head.bof;
  assign o_eof   = o_valid & head.eof;
  assign o_err   = err_q;

endmodule

// File: tb/tb_turbo_symbol_packer.sv
// Scoreboard bench for turbo_symbol_packer with a queue-based frame/packing model.
module tb_turbo_symbol_packer;

  localparam int SymW = 6;
  localparam int Spw  = 5;

  logic        i_clk;
  logic        i_rst;
  logic        i_valid;
  logic [5:0]  i_data;
  logic        i_bof;
  logic        i_eof;
  logic        o_ready;
  logic        o_valid;
  logic [31:0] o_data;
  logic [2:0]  o_count;
  logic        o_bof;
  logic        o_eof;
  logic        i_ready;
  logic        o_err;

  turbo_symbol_packer #(
    .SYM_W(6),
    .SYMS_PER_WORD(5),
    .FIFO_DEPTH(4)
  ) dut (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_valid(i_valid),
    .i_data (i_data),
    .i_bof  (i_bof),
    .i_eof  (i_eof),
    .o_ready(o_ready),
    .o_valid(o_valid),
    .o_data (o_data),
    .o_count(o_count),
    .o_bof  (o_bof),
    .o_eof  (o_eof),
    .i_ready(i_ready),
    .o_err  (o_err)
  );

  typedef struct {
    logic [31:0] data;
    int          count;
    bit          bof;
    bit          eof;
  } word_t;

  int    n_tests = 0;
  int    n_fail  = 0;
  word_t exp_q[$];
  int    sym_q[$];
  bit    m_in_frame, m_wbof, m_err;
  int    ready_mode = 1;  // 0: hold low, 1: hold high, 2: random

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

  function automatic void check(string name, logic [31:0] act, logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, req);
    end
  endfunction

  // Reference model: symbols of the open word kept in a queue.
  function automatic void emit(bit eof);
    word_t w;
    w.data = 32'h0;
    foreach (sym_q[k]) w.data |= 32'(sym_q[k]) << (SymW * k);
    w.count = sym_q.size();
    w.bof   = m_wbof;
    w.eof   = eof;
    exp_q.push_back(w);
    sym_q.delete();
    m_wbof = 1'b0;
  endfunction

  function automatic void model(int d, bit b, bit e);
    if (!m_in_frame && !b) begin
      m_err = 1'b1;
      return;
    end
    if (b) begin
      if (m_in_frame) begin
        m_err = 1'b1;
        if (sym_q.size() > 0) begin
          emit(1'b1);
          m_wbof = 1'b1;
          sym_q.push_back(d);
          return;
        end
      end
      m_in_frame = 1'b1;
      m_wbof     = 1'b1;
      sym_q.push_back(d);
      if (e) begin
        emit(1'b1);
        m_in_frame = 1'b0;
      end
      return;
    end
    sym_q.push_back(d);
    if (e) begin
      emit(1'b1);
      m_in_frame = 1'b0;
    end else if (sym_q.size() == Spw) begin
      emit(1'b0);
    end
  endfunction

  // Monitor: pops one expectation per consumed word.
  initial begin
    word_t w;
    forever begin
      @(negedge i_clk);
      if (!i_rst && o_valid && i_ready) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_word: got data 0x%08h count %0d, want no word", o_data, o_count);
        end else begin
          w = exp_q.pop_front();
          check("word_data", o_data, w.data);
          check("word_count", 32'(o_count), 32'(w.count));
          check("word_bof", 32'(o_bof), 32'(w.bof));
          check("word_eof", 32'(o_eof), 32'(w.eof));
        end
      end
    end
  end

  initial begin
    i_ready = 1'b1;
    forever begin
      @(posedge i_clk);
      #1;
      if (ready_mode == 2) i_ready = ($urandom_range(3) != 0);
      else i_ready = (ready_mode == 1);
    end
  end

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic send(input logic [5:0] d, input bit b, input bit e);
    int guard = 0;
    i_valid = 1'b1;
    i_data  = d;
    i_bof   = b;
    i_eof   = e;
    while (!o_ready && guard < 300) begin
      step();
      guard++;
    end
    if (!o_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL accept_timeout: got o_ready 0 for %0d cycles, want 1", guard);
    end else begin
      model(int'(d), b, e);
      step();
    end
    i_valid = 1'b0;
    i_bof   = 1'b0;
    i_eof   = 1'b0;
  endtask

  task automatic idle(input int n);
    i_valid = 1'b0;
    i_data  = 6'($urandom);
    i_bof   = 1'($urandom);
    i_eof   = 1'($urandom);
    repeat (n) step();
    i_bof = 1'b0;
    i_eof = 1'b0;
  endtask

  task automatic do_reset();
    i_rst   = 1'b1;
    i_valid = 1'b0;
    i_bof   = 1'b0;
    i_eof   = 1'b0;
    step();
    exp_q.delete();
    sym_q.delete();
    m_in_frame = 1'b0;
    m_wbof     = 1'b0;
    m_err      = 1'b0;
    i_rst      = 1'b0;
  endtask

  task automatic drain();
    int guard = 0;
    ready_mode = 1;
    while ((exp_q.size() != 0 || o_valid) && guard < 500) begin
      step();
      guard++;
    end
    check("drain_pending", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int len;
    bit noeof;
    i_rst   = 1'b1;
    i_valid = 1'b0;
    i_data  = '0;
    i_bof   = 1'b0;
    i_eof   = 1'b0;
    step();
    do_reset();
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_data", o_data, 32'd0);
    check("rst_count", 32'(o_count), 32'd0);
    check("rst_bof", 32'(o_bof), 32'd0);
    check("rst_eof", 32'(o_eof), 32'd0);
    check("rst_err", 32'(o_err), 32'd0);
    check("rst_ready", 32'(o_ready), 32'd1);

    // Five-symbol frame, one full word.
    for (int i = 1; i <= 4; i++) send(6'(i), i == 1, 1'b0);
    check("pre_flush_valid", 32'(o_valid), 32'd0);
    send(6'd5, 1'b0, 1'b1);
    check("flush_latency", 32'(o_valid), 32'd1);
    check("frame5_data", o_data, 32'h05103081);
    drain();

    // Seven-symbol frame spans two words.
    for (int i = 0; i < 7; i++) send(6'($urandom), i == 0, i == 6);
    drain();

    // Single-symbol frame.
    send(6'h3F, 1'b1, 1'b1);
    check("single_data", o_data, 32'h0000003F);
    check("single_err", 32'(o_err), 32'd0);
    drain();

    // Back-pressure: four words fill the FIFO.
    ready_mode = 0;
    idle(2);
    for (int i = 0; i < 20; i++) send(6'($urandom), i == 0, 1'b0);
    check("bp_ready_low", 32'(o_ready), 32'd0);
    check("bp_valid", 32'(o_valid), 32'd1);
    ready_mode = 1;
    send(6'($urandom), 1'b0, 1'b0);
    send(6'($urandom), 1'b0, 1'b1);
    drain();

    // bof without preceding eof, then a stray symbol in IDLE.
    for (int i = 0; i < 3; i++) send(6'($urandom), i == 0, 1'b0);
    for (int i = 0; i < 4; i++) send(6'($urandom), i == 0, i == 3);
    check("missing_eof_err", 32'(o_err), 32'd1);
    send(6'($urandom), 1'b0, 1'b0);
    check("err_sticky", 32'(o_err), 32'd1);
    drain();

    // Reset mid-frame with two words buffered.
    ready_mode = 0;
    idle(2);
    for (int i = 0; i < 12; i++) send(6'($urandom), i == 0, 1'b0);
    check("pre_rst_valid", 32'(o_valid), 32'd1);
    do_reset();
    check("midrst_valid", 32'(o_valid), 32'd0);
    check("midrst_err", 32'(o_err), 32'd0);
    check("midrst_ready", 32'(o_ready), 32'd1);
    ready_mode = 1;
    for (int i = 0; i < 3; i++) send(6'($urandom), i == 0, i == 2);
    drain();
    check("post_rst_err", 32'(o_err), 32'd0);
    send(6'($urandom), 1'b0, 1'b1);
    check("stray_drop_err", 32'(o_err), 32'd1);
    drain();

    // Randomised frames under random back-pressure.
    ready_mode = 2;
    for (int f = 0; f < 60; f++) begin
      if (!m_in_frame && $urandom_range(9) == 0) send(6'($urandom), 1'b0, 1'($urandom));
      len   = $urandom_range(1, 12);
      noeof = ($urandom_range(7) == 0);
      if (m_in_frame && sym_q.size() > 0 && len == 1) len = 2;
      for (int i = 0; i < len; i++) begin
        send(6'($urandom), i == 0, (i == len - 1) && !noeof);
        if ($urandom_range(3) == 0) idle($urandom_range(1, 3));
      end
    end
    drain();
    check("final_err", 32'(o_err), 32'(m_err));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
